rv_alu1_stage: RTL and testbench

- Execute stage register directly downstream of the operand forwarding unit in the FlexRV32 core.
- Consumes the forwarded operands, computes the integer ALU result, and registers it into the ALU2 slot.
- Its registered rd / reg-write / result are the ALU2 forwarding source fed back to the forwarding unit.
- Owns the load-use interlock and the decode→execute valid/ready handshake; counts interlock stalls.

---
 rtl/rv_alu1_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_rv_alu1_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu1_stage.sv
// ============================================================================
// rv_alu1_stage
// ----------------------------------------------------------------------------
// Execute stage of the FlexRV32 core. It sits directly after the operand
// forwarding unit. It takes the forwarded operands, computes the integer ALU
// result and registers it into the ALU2 slot. The registered rd, reg-write and
// result of this slot are fed back to the forwarding unit as the ALU2 source.
//
// The stage also owns three pieces of control:
//   - the load-use interlock,
//   - the decode->execute valid/ready handshake,
//   - a saturating counter of load-use stall cycles.
//
// Ports
//   i_clk, i_reset_n        clock; asynchronous active-low reset
//   i_flush                 kill the occupant and any incoming instruction
//   i_valid / o_ready       decode -> execute handshake (o_ready is combinational)
//   i_rs1, i_rs2,
//   i_use_rs1, i_use_rs2    source register indices and their use flags,
//                           used for load-use hazard detection
//   i_rd, i_reg_write,
//   i_is_load               destination register and instruction kind
//   i_op, i_src2_imm, i_imm ALU opcode and operand-B select / immediate
//   i_data1, i_data2        forwarded operands
//   i_ready                 downstream stage accepts the occupant
//   o_valid                 stage holds a valid instruction
//   o_rd, o_reg_write,
//   o_is_load               registered instruction fields
//   o_fwd_reg_write         ALU2 forwarding write enable (valid, non-load writer)
//   o_result                registered ALU result / load-store address
//   o_store_data            registered operand 2 (store data)
//   o_stall_cnt             saturating load-use stall cycle counter
// ============================================================================
module rv_alu1_stage #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic             i_use_rs1,
    input  logic             i_use_rs2,
    input  logic [4:0]       i_rd,
    input  logic             i_reg_write,
    input  logic             i_is_load,
    input  logic [3:0]       i_op,
    input  logic             i_src2_imm,
    input  logic [31:0]      i_imm,
    input  logic [31:0]      i_data1,
    input  logic [31:0]      i_data2,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [4:0]       o_rd,
    output logic             o_fwd_reg_write,
    output logic             o_reg_write,
    output logic             o_is_load,
    output logic [31:0]      o_result,
    output logic [31:0]      o_store_data,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Integer ALU. Add and subtract wrap modulo 2^32. Shifts use B[4:0].
    // Unused opcodes 11-15 produce zero.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] alu_calc(
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic signed [31:0] a_s;
        logic signed [31:0] b_s;
        logic [4:0]         shamt;
        logic [31:0]        r;
        a_s   = a;
        b_s   = b;
        shamt = b[4:0];
        case (op)
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_SLL:   r = a << shamt;
            ALU_SLT:   r = {31'd0, (a_s < b_s)};
            ALU_SLTU:  r = {31'd0, (a < b)};
            ALU_XOR:   r = a ^ b;
            ALU_SRL:   r = a >> shamt;
            ALU_SRA:   r = $unsigned(a_s >>> shamt);
            ALU_OR:    r = a | b;
            ALU_AND:   r = a & b;
            ALU_PASSB: r = b;
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

    // The counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic             valid_q,      valid_d;
    logic [4:0]       rd_q,         rd_d;
    logic             reg_write_q,  reg_write_d;
    logic             is_load_q,    is_load_d;
    logic [31:0]      result_q,     result_d;
    logic [31:0]      store_data_q, store_data_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        load_use;
    logic        ready;
    logic        accept;

    assign op_b    = i_src2_imm ? i_imm : i_data2;
    assign alu_res = alu_calc(i_op, i_data1, op_b);

    // A load in this slot has no data yet; its value only exists once it
    // reaches the write stage. A consumer of its rd must therefore wait one
    // slot. x0 is never a real dependency.
    assign rs1_hit  = i_use_rs1 & (i_rs1 == rd_q);
    assign rs2_hit  = i_use_rs2 & (i_rs2 == rd_q);
    assign load_use = valid_q & is_load_q & reg_write_q & (rd_q != 5'd0)
                    & (rs1_hit | rs2_hit);

    assign ready  = !i_flush & !load_use & (!valid_q | i_ready);
    assign accept = i_valid & ready;

    // ------------------------------------------------------------------------
    // Next state. Flush wins over accept, accept wins over drain, and
    // otherwise the state holds. Flush only clears the valid bit; the stale
    // fields remain visible but are masked by o_fwd_reg_write.
    // ------------------------------------------------------------------------
    always_comb begin
        valid_d      = valid_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        is_load_d    = is_load_q;
        result_d     = result_q;
        store_data_d = store_data_q;
        stall_cnt_d  = stall_cnt_q;

        if (i_flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d      = 1'b1;
            rd_d         = i_rd;
            reg_write_d  = i_reg_write;
            is_load_d    = i_is_load;
            result_d     = alu_res;
            store_data_d = i_data2;
        end else if (valid_q & i_ready) begin
            valid_d = 1'b0;
        end

        // Count only cycles in which a real instruction is held back by the
        // interlock.
        if (i_valid & load_use & !i_flush) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q      <= 1'b0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            is_load_q    <= 1'b0;
            result_q     <= 32'd0;
            store_data_q <= 32'd0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            is_load_q    <= is_load_d;
            result_q     <= result_d;
            store_data_q <= store_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_ready         = ready;
    assign o_valid         = valid_q;
    assign o_rd            = rd_q;
    assign o_reg_write     = reg_write_q;
    assign o_is_load       = is_load_q;
    assign o_result        = result_q;
    assign o_store_data    = store_data_q;
    assign o_stall_cnt     = stall_cnt_q;
    // A load's result is an address, not register data, so it is never
    // forwarded from this slot.
    assign o_fwd_reg_write = valid_q & reg_write_q & !is_load_q;

endmodule

// File: tb/tb_rv_alu1_stage.sv
module tb_rv_alu1_stage;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic        i_use_rs1;
    logic        i_use_rs2;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic        i_is_load;
    logic [3:0]  i_op;
    logic        i_src2_imm;
    logic [31:0] i_imm;
    logic [31:0] i_data1;
    logic [31:0] i_data2;
    logic        i_ready;
    logic        o_valid;
    logic [4:0]  o_rd;
    logic        o_fwd_reg_write;
    logic        o_reg_write;
    logic        o_is_load;
    logic [31:0] o_result;
    logic [31:0] o_store_data;
    logic [15:0] o_stall_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    rv_alu1_stage #(.CNT_W(16)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_flush        (i_flush),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_rs1          (i_rs1),
        .i_rs2          (i_rs2),
        .i_use_rs1      (i_use_rs1),
        .i_use_rs2      (i_use_rs2),
        .i_rd           (i_rd),
        .i_reg_write    (i_reg_write),
        .i_is_load      (i_is_load),
        .i_op           (i_op),
        .i_src2_imm     (i_src2_imm),
        .i_imm          (i_imm),
        .i_data1        (i_data1),
        .i_data2        (i_data2),
        .i_ready        (i_ready),
        .o_valid        (o_valid),
        .o_rd           (o_rd),
        .o_fwd_reg_write(o_fwd_reg_write),
        .o_reg_write    (o_reg_write),
        .o_is_load      (o_is_load),
        .o_result       (o_result),
        .o_store_data   (o_store_data),
        .o_stall_cnt    (o_stall_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src_imm, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2);
        i_valid     = 1'b1;
        i_op        = op;
        i_data1     = a;
        i_data2     = b;
        i_imm       = imm;
        i_src2_imm  = src_imm;
        i_rd        = rd;
        i_reg_write = rw;
        i_is_load   = ld;
        i_rs1       = rs1;
        i_rs2       = rs2;
        i_use_rs1   = u1;
        i_use_rs2   = u2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        check_val({tag, "_rd"}, {27'd0, o_rd}, 32'd0);
        check_val({tag, "_rw"}, {31'd0, o_reg_write}, 32'd0);
        check_val({tag, "_ld"}, {31'd0, o_is_load}, 32'd0);
        check_val({tag, "_result"}, o_result, 32'd0);
        check_val({tag, "_store"}, o_store_data, 32'd0);
        check_val({tag, "_cnt"}, {16'd0, o_stall_cnt}, 32'd0);
        check_val({tag, "_fwd"}, {31'd0, o_fwd_reg_write}, 32'd0);
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_flush   = 1'b0;
        i_ready   = 1'b1;
        instr(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        i_valid   = 1'b0;
        #3;
        check_reset_outputs("reset");
        step();
        i_reset_n = 1'b1;

        // ---------------- ALU operations ----------------
        instr(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1);
        #1 check_val("add_ready", {31'd0, o_ready}, 32'd1);
        step();
        check_val("add_valid", {31'd0, o_valid}, 32'd1);
        check_val("add_result", o_result, 32'd0);
        check_val("add_rd", {27'd0, o_rd}, 32'd3);
        check_val("add_fwd", {31'd0, o_fwd_reg_write}, 32'd1);
        check_val("add_store", o_store_data, 32'd1);

        instr(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd4, 1'b1, 1'b0, 5'd1, 5'd0, 1'b1, 1'b0);
        #1 check_val("sra_ready", {31'd0, o_ready}, 32'd1);
        step();
        check_val("sra_result", o_result, 32'hF800_0000);

        instr(4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        check_val("slt_result", o_result, 32'd1);

        instr(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        check_val("sltu_result", o_result, 32'd0);

        instr(4'd1, 32'd0, 32'd1, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        check_val("sub_result", o_result, 32'hFFFF_FFFF);

        instr(4'd12, 32'h1234_5678, 32'h0000_00FF, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1);
        step();
        check_val("op12_result", o_result, 32'd0);

        instr(4'd10, 32'h1111_1111, 32'h2222_2222, 32'hABCD_0000, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        check_val("passb_result", o_result, 32'hABCD_0000);
        check_val("passb_store", o_store_data, 32'h2222_2222);

        // ---------------- Load-use via rs1 ----------------
        instr(4'd0, 32'h100, 32'd0, 32'd8, 1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0);
        step();
        check_val("ld_valid", {31'd0, o_valid}, 32'd1);
        check_val("ld_isload", {31'd0, o_is_load}, 32'd1);
        check_val("ld_fwd", {31'd0, o_fwd_reg_write}, 32'd0);
        check_val("ld_result", o_result, 32'h108);

        instr(4'd0, 32'd7, 32'd1, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0);
        #1 check_val("lu1_ready_lo", {31'd0, o_ready}, 32'd0);
        step();
        check_val("lu1_bubble_valid", {31'd0, o_valid}, 32'd0);
        check_val("lu1_bubble_fwd", {31'd0, o_fwd_reg_write}, 32'd0);
        check_val("lu1_bubble_stale", o_result, 32'h108);
        check_val("lu1_cnt", {16'd0, o_stall_cnt}, 32'd1);
        #1 check_val("lu1_ready_hi", {31'd0, o_ready}, 32'd1);
        step();
        check_val("lu1_dep_valid", {31'd0, o_valid}, 32'd1);
        check_val("lu1_dep_result", o_result, 32'd8);
        check_val("lu1_dep_rd", {27'd0, o_rd}, 32'd6);
        check_val("lu1_cnt_hold", {16'd0, o_stall_cnt}, 32'd1);

        // ---------------- Load-use via rs2 ----------------
        instr(4'd0, 32'h40, 32'd0, 32'd0, 1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        instr(4'd5, 32'hF0, 32'hFF, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 5'd9, 1'b0, 1'b1);
        #1 check_val("lu2_ready_lo", {31'd0, o_ready}, 32'd0);
        step();
        check_val("lu2_bubble_valid", {31'd0, o_valid}, 32'd0);
        check_val("lu2_cnt", {16'd0, o_stall_cnt}, 32'd2);
        step();
        check_val("lu2_dep_result", o_result, 32'h0F);
        check_val("lu2_dep_valid", {31'd0, o_valid}, 32'd1);

        // ---------------- Load to x0 never interlocks ----------------
        instr(4'd0, 32'h200, 32'd0, 32'd4, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        instr(4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
        #1 check_val("x0_ready", {31'd0, o_ready}, 32'd1);
        step();
        check_val("x0_result", o_result, 32'd30);
        check_val("x0_valid", {31'd0, o_valid}, 32'd1);
        check_val("x0_cnt", {16'd0, o_stall_cnt}, 32'd2);

        // ---------------- Downstream stall ----------------
        i_ready = 1'b0;
        instr(4'd8, 32'h0F00, 32'h00F0, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 check_val("ds_ready_lo", {31'd0, o_ready}, 32'd0);
            step();
            check_val("ds_hold_valid", {31'd0, o_valid}, 32'd1);
            check_val("ds_hold_result", o_result, 32'd30);
            check_val("ds_hold_rd", {27'd0, o_rd}, 32'd6);
        end
        i_ready = 1'b1;
        #1 check_val("ds_ready_hi", {31'd0, o_ready}, 32'd1);
        step();
        check_val("ds_next_result", o_result, 32'h0FF0);
        check_val("ds_next_rd", {27'd0, o_rd}, 32'd8);

        // ---------------- Flush with incoming instruction ----------------
        instr(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        i_flush = 1'b1;
        #1 check_val("fl_ready", {31'd0, o_ready}, 32'd0);
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check_val("fl_valid", {31'd0, o_valid}, 32'd0);
        check_val("fl_fwd", {31'd0, o_fwd_reg_write}, 32'd0);
        check_val("fl_result_hold", o_result, 32'h0FF0);
        check_val("fl_rd_hold", {27'd0, o_rd}, 32'd8);

        // ---------------- Flush while downstream stalled ----------------
        instr(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        check_val("fs_result", o_result, 32'd5);
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b1;
        step();
        check_val("fs_valid", {31'd0, o_valid}, 32'd0);
        i_flush = 1'b0;
        i_ready = 1'b1;

        // ---------------- Asynchronous reset mid-stream ----------------
        instr(4'd0, 32'h1230, 32'd4, 32'd0, 1'b0, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        check_val("ar_pre_result", o_result, 32'h1234);
        i_valid = 1'b0;
        #1 i_reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        step();
        i_reset_n = 1'b1;

        // ---------------- Load held downstream: counter saturation ----------------
        instr(4'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd12, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        i_ready = 1'b0;
        instr(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd13, 1'b1, 1'b0, 5'd12, 5'd0, 1'b1, 1'b0);
        repeat (3) step();
        check_val("sat_cnt3", {16'd0, o_stall_cnt}, 32'd3);
        check_val("sat_ready_lo", {31'd0, o_ready}, 32'd0);
        check_val("sat_load_stays", {31'd0, o_valid}, 32'd1);
        repeat (65535) step();
        check_val("sat_cnt_max", {16'd0, o_stall_cnt}, 32'h0000_FFFF);
        check_val("sat_rd_hold", {27'd0, o_rd}, 32'd12);
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
